ct_spsram_256x59_ctrl: RTL and testbench

Access controller that drives one 256-entry × 59-bit single-port SRAM (active-low CEN/GWEN/bit-WEN macro, one-cycle read latency) on behalf of one IFU client. After reset or an explicit flush it clears all 256 entries, writing zero to one entry per cycle. Outside that clear sequence it serves single read or masked-write requests through a valid/ready handshake and returns read data in a registered output. It sits between the IFU array logic and the SRAM wrapper, one instance per array.

---
 rtl/ct_spsram_256x59_ctrl.sv | 132 +++++++++++++
 tb/tb_ct_spsram_256x59_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_256x59_ctrl.sv
// Access controller for a 256x59 single-port SRAM: clears the array after reset/flush,
// then serves single reads (two-cycle turnaround) and masked writes for one IFU client.
module ct_spsram_256x59_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 59
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  flush_req,
    output logic                  init_done,
    input  logic                  req_vld,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  req_rdy,
    output logic                  rdata_vld,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] INIT    = 2'd0;
    localparam logic [1:0] IDLE    = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rdata_vld_q, rdata_vld_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  acc;
    logic                  cen_c, gwen_c;
    logic [ADDR_WIDTH-1:0] a_c;
    logic [DATA_WIDTH-1:0] wen_c, d_c;

    // Handshake: a request transfers in any cycle where req_vld and req_rdy are both high;
    // req_rdy never depends on req_vld, and a flush blocks acceptance in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;
        req_rdy     = (state_q == IDLE) && !flush_req;
        acc         = req_vld && req_rdy;
        cen_c       = 1'b1;
        gwen_c      = 1'b1;
        wen_c       = '1;
        a_c         = '0;
        d_c         = '0;
        case (state_q)
            INIT: begin
                cen_c  = 1'b0;
                gwen_c = 1'b0;
                wen_c  = '0;
                a_c    = cnt_q;
                if (flush_req) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_d = IDLE;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else if (acc) begin
                    cen_c = 1'b0;
                    a_c   = req_addr;
                    if (req_wr) begin
                        gwen_c = 1'b0;
                        wen_c  = ~req_wmask;
                        d_c    = req_wdata;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // The pending read always completes; a flush only redirects the next state.
                rdata_d     = sram_q;
                rdata_vld_d = 1'b1;
                cnt_d       = '0;
                state_d     = flush_req ? INIT : IDLE;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
        init_done_d = (state_d != INIT);
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rdata_vld_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rdata_vld_q <= rdata_vld_d;
            rdata_q     <= rdata_d;
        end
    end

    // The INIT state drives an access, so reset must force the macro inputs inactive directly.
    assign sram_cen  = cpurst_b ? cen_c  : 1'b1;
    assign sram_gwen = cpurst_b ? gwen_c : 1'b1;
    assign sram_wen  = cpurst_b ? wen_c  : '1;
    assign sram_a    = cpurst_b ? a_c    : '0;
    assign sram_d    = cpurst_b ? d_c    : '0;

    assign init_done = init_done_q;
    assign rdata_vld = rdata_vld_q;
    assign rdata     = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ct_spsram_256x59_ctrl.sv
// Bench for ct_spsram_256x59_ctrl: behavioural SRAM macro, reference memory model and a
// scoreboard of expected read data and arrival cycles.
module tb_ct_spsram_256x59_ctrl;

    localparam int AW = 8;
    localparam int DW = 59;
    localparam logic [DW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          cpurst_b;
    logic          flush_req;
    logic          init_done;
    logic          req_vld;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          req_rdy;
    logic          rdata_vld;
    logic [DW-1:0] rdata;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;
    logic [1:0]    dbg_state;

    ct_spsram_256x59_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk),
        .cpurst_b(cpurst_b),
        .flush_req(flush_req),
        .init_done(init_done),
        .req_vld(req_vld),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_wmask(req_wmask),
        .req_rdy(req_rdy),
        .rdata_vld(rdata_vld),
        .rdata(rdata),
        .sram_a(sram_a),
        .sram_cen(sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen(sram_wen),
        .sram_d(sram_d),
        .sram_q(sram_q),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            compared   = 0;
    int            mismatched = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] ref_mem[256];
    logic [DW-1:0] last_rd = '0;

    function automatic logic [DW-1:0] rand_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // SRAM macro: random power-up contents so the clear sequence is observable.
    logic [DW-1:0] mem[256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rand_data();
        sram_q = rand_data();
        forever begin
            @(posedge clk);
            if (!sram_cen) begin
                if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
                else sram_q <= mem[sram_a];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    task automatic monitor();
        logic [DW-1:0] e;
        int            ec;
        forever begin
            @(negedge clk);
            if (rdata_vld) begin
                if (exp_q.size() == 0) begin
                    check("rdata_vld_unexpected", 64'(1), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("rdata", 64'(rdata), 64'(e));
                    check("rdata_cycle", 64'(cyc), 64'(ec));
                    last_rd = rdata;
                end
            end
        end
    endtask

    // Called right after the edge that starts a clear; checks every clear access in order.
    task automatic check_clear(input int flush_at, input int abort_at);
        int e;
        int n;
        e = 0;
        n = 0;
        while (e < 256) begin
            @(negedge clk);
            flush_req = 1'b0;
            check("clr_a", 64'(sram_a), 64'(e));
            check("clr_ctl", 64'({sram_cen, sram_gwen, init_done, req_rdy}), 64'(0));
            check("clr_wen", 64'(sram_wen), 64'(0));
            check("clr_d", 64'(sram_d), 64'(0));
            if (n == abort_at) return;
            if (n == flush_at) begin
                flush_req = 1'b1;
                e = 0;
            end else begin
                e++;
            end
            n++;
        end
        @(negedge clk);
        check("clr_done", 64'({init_done, req_rdy}), 64'(2'b11));
    endtask

    task automatic start_flush();
        flush_req = 1'b1;
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        ref_clear();
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask, output int acc_cyc, output int waits);
        logic [DW-1:0] nm;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        waits     = 0;
        acc_cyc   = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                acc_cyc = cyc;
                break;
            end
            waits++;
        end
        if (acc_cyc < 0) begin
            check("req_timeout", 64'(0), 64'(1));
        end else if (wr) begin
            nm = ~mask;
            check("wr_ctl", 64'({sram_cen, sram_gwen}), 64'(0));
            check("wr_a", 64'(sram_a), 64'(addr));
            check("wr_wen", 64'(sram_wen), 64'(nm));
            check("wr_d", 64'(sram_d), 64'(data));
            ref_mem[addr] = (ref_mem[addr] & ~mask) | (data & mask);
        end else begin
            check("rd_ctl", 64'({sram_cen, sram_gwen}), 64'(2'b01));
            check("rd_a", 64'(sram_a), 64'(addr));
            check("rd_wen", 64'(sram_wen), 64'(ONES));
            exp_q.push_back(ref_mem[addr]);
            exp_cyc_q.push_back(acc_cyc + 2);
        end
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    initial begin
        int            c0, c1, c2, r0, r1, w;
        logic [DW-1:0] m;
        logic [AW-1:0] ad;
        int            k;
        cpurst_b  = 1'b0;
        flush_req = 1'b0;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 64'({sram_cen, sram_gwen, init_done, req_rdy, rdata_vld}), 64'(5'b11000));
        check("rst_wen", 64'(sram_wen), 64'(ONES));
        check("rst_ad", 64'({sram_a, sram_d}), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        ref_clear();
        check_clear(-1, -1);
        @(posedge clk);
        #1;

        // Read after the clear returns zero, two cycles after accept
        do_req(1'b0, 8'h80, '0, '0, c0, w);

        // Full write then single-bit write
        do_req(1'b1, 8'h05, ONES, ONES, c0, w);
        do_req(1'b1, 8'h05, '0, 59'h1, c0, w);
        do_req(1'b0, 8'h05, '0, '0, c0, w);

        // Back-to-back writes and reads
        do_req(1'b1, 8'h30, rand_data(), ONES, c0, w);
        do_req(1'b1, 8'h31, rand_data(), ONES, c1, w);
        do_req(1'b1, 8'h32, rand_data(), rand_data(), c2, w);
        check("b2b_wr1", 64'(c1 - c0), 64'(1));
        check("b2b_wr2", 64'(c2 - c1), 64'(1));
        do_req(1'b0, 8'h30, '0, '0, r0, w);
        do_req(1'b0, 8'h31, '0, '0, r1, w);
        check("b2b_rd_gap", 64'(r1 - r0), 64'(2));
        check("b2b_rd_wait", 64'(w), 64'(1));

        // Random traffic over a small address window so reads hit earlier writes
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 3);
            m = (k == 0) ? ONES : (k == 1) ? '0 : rand_data();
            ad = 8'($urandom_range(0, 15));
            do_req(1'($urandom_range(0, 1)), ad, rand_data(), m, c0, w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Flush and write in the same IDLE cycle: the write must be dropped
        flush_req = 1'b1;
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 59'h5A;
        req_wmask = ONES;
        @(negedge clk);
        check("flush_wr_rdy", 64'(req_rdy), 64'(0));
        check("flush_wr_cen", 64'(sram_cen), 64'(1));
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        req_vld   = 1'b0;
        ref_clear();
        check_clear(-1, -1);
        @(posedge clk);
        #1;
        do_req(1'b0, 8'h10, '0, '0, c0, w);

        // Flush while a read is pending
        do_req(1'b1, 8'h22, rand_data(), ONES, c0, w);
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 8'h22;
        @(negedge clk);
        check("flr_acc", 64'(req_rdy), 64'(1));
        exp_q.push_back(ref_mem[8'h22]);
        exp_cyc_q.push_back(cyc + 2);
        @(posedge clk);
        #1;
        req_vld   = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        check("flr_rdwait", 64'({req_rdy, sram_cen}), 64'(2'b01));
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        ref_clear();
        check_clear(-1, -1);
        check("rdata_hold", 64'(rdata), 64'(last_rd));
        @(posedge clk);
        #1;

        // Flush at clear count 100 restarts the count
        start_flush();
        check_clear(100, -1);
        @(posedge clk);
        #1;

        // Reset at clear count 50
        start_flush();
        check_clear(-1, 50);
        cpurst_b = 1'b0;
        #1;
        check("mid_rst_ctl", 64'({sram_cen, sram_gwen, init_done, req_rdy, rdata_vld}), 64'(5'b11000));
        check("mid_rst_wen", 64'(sram_wen), 64'(ONES));
        check("mid_rst_ad", 64'({sram_a, sram_d}), 64'(0));
        check("mid_rst_rdata", 64'(rdata), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        ref_clear();
        check_clear(-1, -1);
        @(posedge clk);
        #1;
        do_req(1'b0, 8'hC7, '0, '0, c0, w);
        do_req(1'b1, 8'hC7, rand_data(), rand_data(), c0, w);
        do_req(1'b0, 8'hC7, '0, '0, c0, w);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
